// File: rtl/score_accumulator_pkg.sv
// Shared constants for the piano scoring path: FSM encodings, score width,
// and default penalty/grace settings.
package score_accumulator_pkg;

    localparam int SCORE_W = 41;
    localparam int GRACE_W = 24;
    localparam int KEY_W   = 7;

    // Largest representable score; every addition clamps here.
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    // Defaults sized for a 100 MHz clock.
    localparam logic [SCORE_W-1:0] DEF_MISS_PENALTY = 41'd500_000_000;
    localparam logic [GRACE_W-1:0] DEF_GRACE        = 24'd10_000_000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/score_accumulator_sat_add41.sv
// Combinational 41-bit saturating adder: clamps at all-ones instead of wrapping.
module sat_add41
    import score_accumulator_pkg::*;
(
    input  logic [SCORE_W-1:0] a,
    input  logic [SCORE_W-1:0] b,
    output logic [SCORE_W-1:0] y
);

    logic [SCORE_W:0] sum_w;

    // Carry out of the top bit means overflow; clamp to the maximum score.
    always_comb begin
        sum_w = {1'b0, a} + {1'b0, b};
        y     = sum_w[SCORE_W] ? SCORE_MAX : sum_w[SCORE_W-1:0];
    end

endmodule

// File: rtl/score_accumulator.sv
// Learning-mode scoring FSM: accumulates mismatch cycles and missed-note
// penalties into a saturating 41-bit score while a song plays.
module score_accumulator
    import score_accumulator_pkg::*;
#(
    parameter logic [SCORE_W-1:0] MISS_PENALTY = DEF_MISS_PENALTY,
    parameter logic [GRACE_W-1:0] GRACE        = DEF_GRACE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [KEY_W-1:0]   expected,
    input  logic [KEY_W-1:0]   key,
    output logic [SCORE_W-1:0] score,
    output logic               busy,
    output logic               done
);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [GRACE_W-1:0] grace_q, grace_d;
    logic               hit_q, hit_d;
    logic [KEY_W-1:0]   prev_q, prev_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               add_en;
    logic               add_miss;
    logic [SCORE_W-1:0] add_inc;
    logic [SCORE_W-1:0] add_sum;

    // A miss penalty and a mismatch tick never coincide, so one adder serves both.
    assign add_inc = add_miss ? MISS_PENALTY : SCORE_W'(1);

    sat_add41 u_add (
        .a (score_q),
        .b (add_inc),
        .y (add_sum)
    );

    // Next-state: start overrides everything, then stop, note change, grace, mismatch.
    always_comb begin
        state_d  = state_q;
        grace_d  = grace_q;
        hit_d    = hit_q;
        prev_d   = prev_q;
        add_en   = 1'b0;
        add_miss = 1'b0;
        score_d  = score_q;

        if (start) begin
            state_d = ST_PLAY;
            score_d = '0;
            hit_d   = 1'b0;
            grace_d = GRACE;
            prev_d  = expected;
        end else if (state_q == ST_PLAY) begin
            if (stop) begin
                add_miss = 1'b1;
                add_en   = (prev_q != '0) && !hit_q;
                state_d  = ST_DONE;
            end else if (expected != prev_q) begin
                add_miss = 1'b1;
                add_en   = (prev_q != '0) && !hit_q;
                prev_d   = expected;
                grace_d  = GRACE;
                hit_d    = 1'b0;
            end else begin
                if (grace_q != '0) begin
                    grace_d = grace_q - GRACE_W'(1);
                end else if (key != expected) begin
                    add_en = 1'b1;
                end
                if ((expected != '0) && (key == expected)) begin
                    hit_d = 1'b1;
                end
            end
            if (add_en) begin
                score_d = add_sum;
            end
        end

        busy_d = (state_d == ST_PLAY);
        done_d = (state_d == ST_DONE);
    end

    // State and registered outputs; synchronous reset wins over start/stop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            score_q <= '0;
            grace_q <= '0;
            hit_q   <= 1'b0;
            prev_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            grace_q <= grace_d;
            hit_q   <= hit_d;
            prev_q  <= prev_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign score = score_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: doc/score_accumulator.md
# score_accumulator

Learning-mode scoring stage for the piano. While a song plays, it compares the debounced key state against the expected note each cycle and accumulates a penalty score: mismatch cycles plus a fixed penalty per missed note. The resulting 41-bit score feeds the level-grading stage that maps it to the Good/SoSo/Bad 7-segment message. Higher score means worse playing.

## Interface

- MISS_PENALTY, 500_000_000: added once per expected note never correctly pressed.
- GRACE, 10_000_000: cycles after each note change during which mismatches are not counted (100 ms at 100 MHz).

- clk  in  1  system clock; one clock domain.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle pulse that begins or restarts a scoring session.
- stop  in  1  single-cycle pulse marking end of song.
- expected  in  7  one-hot expected key; 0 = rest.
- key  in  7  debounced key state.
- score  out  41  accumulated penalty, registered.
- busy  out  1  high while in PLAY.
- done  out  1  high while in DONE; score is final.

## Operation

- States: IDLE, PLAY, DONE.
- Reset: state IDLE, score 0, busy 0, done 0, grace counter 0, hit 0, prev_expected 0.
- start in any state: go to PLAY. Clear score and hit, load grace with GRACE, set prev_expected to expected. start has priority over stop.
- PLAY, per cycle, in priority order:
  - stop: if prev_expected ≠ 0 and hit = 0, add MISS_PENALTY. Then go to DONE.
  - Note change (expected ≠ prev_expected): if prev_expected ≠ 0 and hit = 0, add MISS_PENALTY. Update prev_expected, reload grace to GRACE, clear hit. No mismatch counted this cycle.
  - Otherwise, if grace > 0: decrement grace. No mismatch counted.
  - Otherwise, if key ≠ expected: add 1. This applies during rests as well (any key pressed while expected = 0).
  - hit is set on any non-change cycle where expected ≠ 0 and key = expected, including during grace.
- DONE: score holds; stop is ignored; start restarts.
- IDLE: score holds at 0; stop is ignored.
- Arithmetic: all additions are 41-bit saturating at 2^41−1 = 2_199_023_255_551. The score never wraps.
- Reset mid-session: IDLE and score 0 at the next edge, regardless of start/stop.

## Timing

- All outputs are registered.
- start sampled at edge t: busy = 1 and score = 0 after edge t.
- A penalty qualifying in cycle t is visible on score after edge t (1-cycle latency).
- stop at edge t: final miss penalty and done = 1 both visible after edge t. busy drops at the same edge.
- Mismatch counting: with N PLAY cycles on one note (start-load cycle excluded), the count is max(0, N − GRACE) mismatch cycles, assuming key is wrong throughout.
- Inputs are synchronous and already debounced. No synchronizer is inside this block.

## Structure

- State encodings, the 41-bit score width, and default MISS_PENALTY/GRACE belong in the shared constants header. The level-grading thresholds already live there.
- One sub-module is natural: sat_add41 (combinational 41-bit saturating adder, 41-bit operand). The FSM instantiates it once and muxes the increment between 1 and MISS_PENALTY. Both are never needed in the same cycle.
- Grace counter is 24 bits, sized for GRACE ≤ 2^24−1.

## Test plan

All scenarios use GRACE = 4 and MISS_PENALTY = 100 unless noted.

- Reset: rst high 2 cycles with random inputs -> score 0, busy 0, done 0; stop pulses in IDLE leave done 0.
- Perfect play: start, expected = 7'b0000001 with key matching every cycle, 10 cycles, then note change to 7'b0000010 with matching key, stop -> score 0, done 1.
- Mismatch then hit: expected = 7'b0000001 held, key = 0 for 20 PLAY cycles, then key correct 3 cycles, stop -> score 16 (20 − GRACE), no miss penalty.
- Missed note: expected 7'b0000001 held 20 PLAY cycles with key = 0, then change to 0 (rest) with key = 0, stop -> score 16 + 100 = 116. Rest with a key pressed 10 cycles after grace -> +10.
- Saturation: MISS_PENALTY = 2^41−10; two missed notes -> score = 2_199_023_255_551 and held through further mismatches.
- Reset mid-PLAY with score 50 -> score 0, IDLE. start in DONE -> score 0, busy 1 after the edge. start and stop in the same cycle -> restart wins.
